// File: rtl/exp5_receptor_medida.sv
// Serial frame decoder for the sonar measurement link.
// Accepts "AAA,DDDD#" ASCII frames one byte per strobe and presents the
// angle and distance as BCD words with a one-cycle pronto strobe.
// Malformed or stalled frames raise a one-cycle erro pulse and are discarded.
// Handshake: recebe_dado is a one-cycle valid strobe with no ready; the byte
// on dado is consumed on every clock edge where recebe_dado is high.
module exp5_receptor_medida #(
    parameter int TIMEOUT = 5_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  dado,
    input  logic        recebe_dado,
    output logic [11:0] angulo,
    output logic [15:0] distancia,
    output logic        pronto,
    output logic        erro,
    output logic [2:0]  db_estado
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        INICIAL    = 3'b000,
        ANGULO     = 3'b001,
        VIRGULA    = 3'b010,
        DISTANCIA  = 3'b011,
        TERMINADOR = 3'b100,
        PRONTO     = 3'b101,
        ERRO       = 3'b110
    } estado_t;

    estado_t        estado, proximo;
    logic [1:0]     indice, indice_next;
    logic [11:0]    stage_ang;
    logic [15:0]    stage_dist;
    logic [TW-1:0]  timer;
    logic           erro_flag;

    logic           is_digit, is_virgula, is_hash;
    logic           counting, timed_out;
    logic           shift_ang, shift_dist, commit;

    assign is_digit   = (dado >= 7'h30) && (dado <= 7'h39);
    assign is_virgula = (dado == 7'h2C);
    assign is_hash    = (dado == 7'h23);

    // The timeout only applies while a frame is partially received.
    assign counting  = (estado == ANGULO) || (estado == VIRGULA) ||
                       (estado == DISTANCIA) || (estado == TERMINADOR);
    assign timed_out = counting && (timer == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end

    // Next-state and datapath control; a strobe always beats the timeout.
    always_comb begin
        proximo     = estado;
        indice_next = indice;
        shift_ang   = 1'b0;
        shift_dist  = 1'b0;
        commit      = 1'b0;
        case (estado)
            INICIAL, PRONTO: begin
                // PRONTO lasts one cycle; a byte arriving there is treated as in INICIAL.
                if (estado == PRONTO) proximo = INICIAL;
                if (recebe_dado && is_digit) begin
                    shift_ang   = 1'b1;
                    indice_next = 2'd1;
                    proximo     = ANGULO;
                end
            end
            ANGULO: begin
                if (recebe_dado) begin
                    if (is_digit) begin
                        shift_ang = 1'b1;
                        if (indice == 2'd2) begin
                            indice_next = 2'd0;
                            proximo     = VIRGULA;
                        end else begin
                            indice_next = indice + 2'd1;
                        end
                    end else begin
                        proximo = ERRO;
                    end
                end else if (timed_out) begin
                    proximo = ERRO;
                end
            end
            VIRGULA: begin
                if (recebe_dado) begin
                    if (is_virgula) begin
                        indice_next = 2'd0;
                        proximo     = DISTANCIA;
                    end else begin
                        proximo = ERRO;
                    end
                end else if (timed_out) begin
                    proximo = ERRO;
                end
            end
            DISTANCIA: begin
                if (recebe_dado) begin
                    if (is_digit) begin
                        shift_dist = 1'b1;
                        if (indice == 2'd3) begin
                            indice_next = 2'd0;
                            proximo     = TERMINADOR;
                        end else begin
                            indice_next = indice + 2'd1;
                        end
                    end else begin
                        proximo = ERRO;
                    end
                end else if (timed_out) begin
                    proximo = ERRO;
                end
            end
            TERMINADOR: begin
                if (recebe_dado) begin
                    if (is_hash) begin
                        commit  = 1'b1;
                        proximo = PRONTO;
                    end else begin
                        proximo = ERRO;
                    end
                end else if (timed_out) begin
                    proximo = ERRO;
                end
            end
            ERRO: begin
                if (recebe_dado && is_hash) proximo = INICIAL;
            end
            default: proximo = INICIAL;
        endcase
    end

    // Staging shift registers, digit index and published outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            indice     <= 2'd0;
            stage_ang  <= 12'h000;
            stage_dist <= 16'h0000;
            angulo     <= 12'h000;
            distancia  <= 16'h0000;
        end else begin
            indice <= indice_next;
            if (shift_ang)  stage_ang  <= {stage_ang[7:0], dado[3:0]};
            if (shift_dist) stage_dist <= {stage_dist[11:0], dado[3:0]};
            if (commit) begin
                angulo    <= stage_ang;
                distancia <= stage_dist;
            end
        end
    end

    // Inter-byte timer: cleared by any accepted byte or state change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                          timer <= '0;
        else if (recebe_dado || proximo != estado || !counting) timer <= '0;
        else                                                timer <= timer + 1'b1;
    end

    // Registered "just entered ERRO" flag so erro is a single-cycle pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) erro_flag <= 1'b0;
        else       erro_flag <= (proximo == ERRO) && (estado != ERRO);
    end

    assign pronto    = (estado == PRONTO);
    assign erro      = erro_flag;
    assign db_estado = estado;

endmodule
